regfile_scoreboard: RTL and testbench

Parametrised register file with a configurable number of combinational read ports, one write-back port with same-cycle bypass, and an integrated scoreboard of pending writes. It replaces the fixed 2-read/1-write 32x32 register file in the core datapath. The issue stage uses it to detect RAW/WAW hazards, and the write-back stage uses it to retire results.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/busy_table.sv | 81 ++++++++
 rtl/regfile_scoreboard.sv | 87 ++++++++
 tb/tb_regfile_scoreboard.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared defaults and helpers for the register file with integrated
// scoreboard. Holds the default data width and register count, the index
// of the hard-wired zero register, and the address-width helper used to
// size every address port.
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int ZERO_IDX      = 0;

    // Address width for a register file of nregs entries.
    // A single-entry file still needs a one-bit address port.
    function automatic int addr_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/busy_table.sv
// busy_table
// Scoreboard of pending writes: one busy bit per architectural register.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ra          [NRD*AW]  read-port addresses for the busy lookups
//   issue_valid/issue_wa  claim of a destination register (set port)
//   wb_valid/wb_wa        retirement of a register (clear port)
//   rd_busy     [NRD]     per-port busy, suppressed by a same-cycle retire
//   issue_ready           claim can be accepted this cycle
//   wb_err                sticky: a retire hit a register that was not busy
module busy_table
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = addr_width(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] ra,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_wa,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_wa,
    output logic [NRD-1:0]    rd_busy,
    output logic              issue_ready,
    output logic              wb_err
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             set_en;
    logic             clr_en;
    logic             err_set;

    // The zero register (when enabled) can never be claimed or retired.
    function automatic logic writable(input logic [AW-1:0] a);
        return !((ZERO_REG != 0) && (int'(a) == ZERO_IDX));
    endfunction

    // Claim/retire decode and next busy vector. The clear is applied before
    // the set so that a claim and a retire of the same register in one cycle
    // leaves it busy: the new claim owns the register after the edge.
    // A retire only counts as an error if the register is idle and is not
    // being claimed in the same cycle.
    always_comb begin
        issue_ready = !writable(issue_wa) || !busy[issue_wa] ||
                      (wb_valid && (wb_wa == issue_wa));
        set_en      = issue_valid && issue_ready && writable(issue_wa);
        clr_en      = wb_valid && writable(wb_wa);
        err_set     = clr_en && !busy[wb_wa] &&
                      !(set_en && (issue_wa == wb_wa));
        busy_nxt    = busy;
        if (clr_en) begin
            busy_nxt[wb_wa] = 1'b0;
        end
        if (set_en) begin
            busy_nxt[issue_wa] = 1'b1;
        end
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i] = busy[ra[i*AW +: AW]] &&
                         !(wb_valid && (wb_wa == ra[i*AW +: AW]));
        end
    end

    // Scoreboard state and sticky error flag; reset drops every claim.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= '0;
            wb_err <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (err_set) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Parametrised register file with NRD combinational read ports, one
// write-back port with same-cycle bypass and a scoreboard of pending writes.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ra        [NRD*AW]      read addresses, port i at [i*AW +: AW]
//   rd        [NRD*XLEN]    read data, port i at [i*XLEN +: XLEN]
//   rd_busy   [NRD]         port i register has an unretired claim
//   issue_valid, issue_wa   destination claim from the issue stage
//   issue_ready             claim accepted (fire = valid & ready)
//   wb_valid, wb_wa, wb_wd  write-back of a result
//   wb_err                  sticky: write-back to a register that was idle
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEFAULT,
    parameter  int NREGS    = NREGS_DEFAULT,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = addr_width(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_busy,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_wa,
    output logic                issue_ready,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_wa,
    input  logic [XLEN-1:0]     wb_wd,
    output logic                wb_err
);

    logic [NREGS-1:0][XLEN-1:0] mem;
    logic                       wb_write;

    function automatic logic writable(input logic [AW-1:0] a);
        return !((ZERO_REG != 0) && (int'(a) == ZERO_IDX));
    endfunction

    assign wb_write = wb_valid && writable(wb_wa);

    // Register storage. Writes to the zero register are dropped, so its
    // flop stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (wb_write) begin
            mem[wb_wa] <= wb_wd;
        end
    end

    // Read muxes: zero register first, then the write-back bypass, then storage.
    always_comb begin
        rd = '0;
        for (int i = 0; i < NRD; i++) begin
            if (!writable(ra[i*AW +: AW])) begin
                rd[i*XLEN +: XLEN] = '0;
            end else if (wb_valid && (wb_wa == ra[i*AW +: AW])) begin
                rd[i*XLEN +: XLEN] = wb_wd;
            end else begin
                rd[i*XLEN +: XLEN] = mem[ra[i*AW +: AW]];
            end
        end
    end

    busy_table #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_busy_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .ra          (ra),
        .issue_valid (issue_valid),
        .issue_wa    (issue_wa),
        .wb_valid    (wb_valid),
        .wb_wa       (wb_wa),
        .rd_busy     (rd_busy),
        .issue_ready (issue_ready),
        .wb_err      (wb_err)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
// Drives two configurations of regfile_scoreboard (default 32x32 with two
// read ports, and 16x64 with four read ports). Each stimulus step pushes the
// hand-computed expected outputs into a queue; a monitor on the falling
// clock edge pops each entry and compares it with the live DUT outputs.
module tb_regfile_scoreboard;

    localparam int AXLEN = 32, ANREGS = 32, ANRD = 2, AAW = 5;
    localparam int BXLEN = 64, BNREGS = 16, BNRD = 4, BAW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   a_rst_n;
    logic [ANRD*AAW-1:0]    a_ra;
    logic [ANRD*AXLEN-1:0]  a_rd;
    logic [ANRD-1:0]        a_rd_busy;
    logic                   a_iv;
    logic [AAW-1:0]         a_iwa;
    logic                   a_ir;
    logic                   a_wv;
    logic [AAW-1:0]         a_wwa;
    logic [AXLEN-1:0]       a_wwd;
    logic                   a_err;

    logic                   b_rst_n;
    logic [BNRD*BAW-1:0]    b_ra;
    logic [BNRD*BXLEN-1:0]  b_rd;
    logic [BNRD-1:0]        b_rd_busy;
    logic                   b_iv;
    logic [BAW-1:0]         b_iwa;
    logic                   b_ir;
    logic                   b_wv;
    logic [BAW-1:0]         b_wwa;
    logic [BXLEN-1:0]       b_wwd;
    logic                   b_err;

    regfile_scoreboard #(
        .XLEN(AXLEN), .NREGS(ANREGS), .NRD(ANRD), .ZERO_REG(1)
    ) dut_a (
        .clk(clk), .rst_n(a_rst_n), .ra(a_ra), .rd(a_rd), .rd_busy(a_rd_busy),
        .issue_valid(a_iv), .issue_wa(a_iwa), .issue_ready(a_ir),
        .wb_valid(a_wv), .wb_wa(a_wwa), .wb_wd(a_wwd), .wb_err(a_err)
    );

    regfile_scoreboard #(
        .XLEN(BXLEN), .NREGS(BNREGS), .NRD(BNRD), .ZERO_REG(1)
    ) dut_b (
        .clk(clk), .rst_n(b_rst_n), .ra(b_ra), .rd(b_rd), .rd_busy(b_rd_busy),
        .issue_valid(b_iv), .issue_wa(b_iwa), .issue_ready(b_ir),
        .wb_valid(b_wv), .wb_wa(b_wwa), .wb_wd(b_wwd), .wb_err(b_err)
    );

    typedef struct {
        string        name;
        int           dut;
        logic [255:0] rd;
        logic [3:0]   busy;
        logic         ready;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Drive one cycle of inputs on the chosen DUT, just after the rising edge.
    task automatic applyStimulus(input int dut, input logic rst,
                                 input int r0, input int r1, input int r2, input int r3,
                                 input logic iv, input int iwa,
                                 input logic wv, input int wwa, input logic [63:0] wwd);
        @(posedge clk);
        #1;
        if (dut == 0) begin
            a_rst_n = rst;
            a_ra    = {AAW'(r1), AAW'(r0)};
            a_iv    = iv;
            a_iwa   = AAW'(iwa);
            a_wv    = wv;
            a_wwa   = AAW'(wwa);
            a_wwd   = wwd[31:0];
        end else begin
            b_rst_n = rst;
            b_ra    = {BAW'(r3), BAW'(r2), BAW'(r1), BAW'(r0)};
            b_iv    = iv;
            b_iwa   = BAW'(iwa);
            b_wv    = wv;
            b_wwa   = BAW'(wwa);
            b_wwd   = wwd;
        end
    endtask

    // Queue the expected outputs for the cycle just driven.
    task automatic checkOutput(input string name, input int dut,
                               input logic [63:0] e0, input logic [63:0] e1,
                               input logic [63:0] e2, input logic [63:0] e3,
                               input logic [3:0] busy, input logic ready, input logic err);
        exp_t e;
        e.name  = name;
        e.dut   = dut;
        if (dut == 0) begin
            e.rd = {192'b0, e1[31:0], e0[31:0]};
        end else begin
            e.rd = {e3, e2, e1, e0};
        end
        e.busy  = busy;
        e.ready = ready;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every queued expectation against the DUT mid-cycle.
    initial begin
        exp_t         e;
        logic [255:0] ard;
        logic [3:0]   abusy;
        logic         aready;
        logic         aerr;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.dut == 0) begin
                    ard    = {192'b0, a_rd};
                    abusy  = {2'b0, a_rd_busy};
                    aready = a_ir;
                    aerr   = a_err;
                end else begin
                    ard    = b_rd;
                    abusy  = b_rd_busy;
                    aready = b_ir;
                    aerr   = b_err;
                end
                n_checks++;
                if (ard !== e.rd || abusy !== e.busy || aready !== e.ready || aerr !== e.err) begin
                    n_fail++;
                    $display("[TB] FAIL %s: got rd=%h busy=%b ready=%b err=%b, want rd=%h busy=%b ready=%b err=%b",
                             e.name, ard, abusy, aready, aerr, e.rd, e.busy, e.ready, e.err);
                end
            end
        end
    end

    initial begin
        a_rst_n = 1'b0; a_ra = '0; a_iv = 1'b0; a_iwa = '0; a_wv = 1'b0; a_wwa = '0; a_wwd = '0;
        b_rst_n = 1'b0; b_ra = '0; b_iv = 1'b0; b_iwa = '0; b_wv = 1'b0; b_wwa = '0; b_wwd = '0;

        // ---------------- configuration A: 32 x 32, 2 read ports ----------------
        applyStimulus(0, 1'b0, 5, 9, 0, 0, 1'b0, 5, 1'b0, 0, 64'h0);
        checkOutput("a_in_reset", 0, 0, 0, 0, 0, 4'b0000, 1'b1, 1'b0);

        for (int i = 0; i < ANREGS; i++) begin
            applyStimulus(0, 1'b1, i, ANREGS - 1 - i, 0, 0, 1'b0, i, 1'b0, 0, 64'h0);
            checkOutput($sformatf("a_reset_read_x%0d", i), 0, 0, 0, 0, 0, 4'b0000, 1'b1, 1'b0);
        end

        // Claim x5, then see it busy, then retire with bypass, then read storage.
        applyStimulus(0, 1'b1, 5, 5, 0, 0, 1'b1, 5, 1'b0, 0, 64'h0);
        checkOutput("a_issue_x5", 0, 0, 0, 0, 0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 5, 0, 0, 0, 1'b0, 5, 1'b0, 0, 64'h0);
        checkOutput("a_x5_busy", 0, 0, 0, 0, 0, 4'b0001, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 5, 5, 0, 0, 1'b0, 5, 1'b1, 5, 64'hDEADBEEF);
        checkOutput("a_x5_bypass", 0, 64'hDEADBEEF, 64'hDEADBEEF, 0, 0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 5, 5, 0, 0, 1'b0, 5, 1'b0, 0, 64'h0);
        checkOutput("a_x5_stored", 0, 64'hDEADBEEF, 64'hDEADBEEF, 0, 0, 4'b0000, 1'b1, 1'b0);

        // Zero register ignores writes and claims.
        applyStimulus(0, 1'b1, 0, 0, 0, 0, 1'b1, 0, 1'b1, 0, 64'h1);
        checkOutput("a_x0_write_issue", 0, 0, 0, 0, 0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 64'h0);
        checkOutput("a_x0_after", 0, 0, 0, 0, 0, 4'b0000, 1'b1, 1'b0);

        // Same-cycle claim and retire of x7: data written, busy remains.
        applyStimulus(0, 1'b1, 7, 7, 0, 0, 1'b1, 7, 1'b1, 7, 64'h11);
        checkOutput("a_x7_issue_wb", 0, 64'h11, 64'h11, 0, 0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 7, 7, 0, 0, 1'b0, 7, 1'b0, 0, 64'h0);
        checkOutput("a_x7_busy", 0, 64'h11, 64'h11, 0, 0, 4'b0011, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 7, 5, 0, 0, 1'b0, 7, 1'b1, 7, 64'h33);
        checkOutput("a_x7_retire", 0, 64'h33, 64'hDEADBEEF, 0, 0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 7, 5, 0, 0, 1'b0, 7, 1'b0, 0, 64'h0);
        checkOutput("a_x7_idle", 0, 64'h33, 64'hDEADBEEF, 0, 0, 4'b0000, 1'b1, 1'b0);

        // Retire of an idle register: data lands, error becomes sticky.
        applyStimulus(0, 1'b1, 9, 9, 0, 0, 1'b0, 9, 1'b1, 9, 64'h22);
        checkOutput("a_x9_wb_idle", 0, 64'h22, 64'h22, 0, 0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 9, 9, 0, 0, 1'b0, 9, 1'b0, 0, 64'h0);
        checkOutput("a_x9_err", 0, 64'h22, 64'h22, 0, 0, 4'b0000, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 3, 9, 0, 0, 1'b1, 3, 1'b0, 0, 64'h0);
        checkOutput("a_issue_x3", 0, 0, 64'h22, 0, 0, 4'b0000, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 3, 9, 0, 0, 1'b0, 3, 1'b0, 0, 64'h0);
        checkOutput("a_x3_busy", 0, 0, 64'h22, 0, 0, 4'b0001, 1'b0, 1'b1);

        // Claim x10 while retiring x3: both take effect.
        applyStimulus(0, 1'b1, 3, 10, 0, 0, 1'b1, 10, 1'b1, 3, 64'h44);
        checkOutput("a_x10_issue_x3_wb", 0, 64'h44, 0, 0, 0, 4'b0000, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 3, 10, 0, 0, 1'b0, 10, 1'b0, 0, 64'h0);
        checkOutput("a_x10_busy", 0, 64'h44, 0, 0, 0, 4'b0010, 1'b0, 1'b1);
        applyStimulus(0, 1'b1, 3, 10, 0, 0, 1'b1, 3, 1'b0, 0, 64'h0);
        checkOutput("a_reissue_x3", 0, 64'h44, 0, 0, 0, 4'b0010, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 3, 10, 0, 0, 1'b0, 3, 1'b0, 0, 64'h0);
        checkOutput("a_x3_x10_busy", 0, 64'h44, 0, 0, 0, 4'b0011, 1'b0, 1'b1);

        // Reset mid-cycle with claims pending: everything clears at once.
        applyStimulus(0, 1'b0, 3, 9, 0, 0, 1'b0, 3, 1'b0, 0, 64'h0);
        checkOutput("a_midreset", 0, 0, 0, 0, 0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 9, 3, 0, 0, 1'b0, 3, 1'b1, 9, 64'h55);
        checkOutput("a_reset_bypass", 0, 64'h55, 0, 0, 0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 9, 3, 0, 0, 1'b0, 3, 1'b0, 0, 64'h0);
        checkOutput("a_after_reset", 0, 0, 0, 0, 0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 10, 7, 0, 0, 1'b0, 10, 1'b0, 0, 64'h0);
        checkOutput("a_after_reset2", 0, 0, 0, 0, 0, 4'b0000, 1'b1, 1'b0);

        // ---------------- configuration B: 16 x 64, 4 read ports ----------------
        applyStimulus(1, 1'b1, 0, 1, 2, 15, 1'b0, 15, 1'b0, 0, 64'h0);
        checkOutput("b_reset_read", 1, 0, 0, 0, 0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1, 1'b1, 3, 3, 0, 15, 1'b1, 3, 1'b0, 0, 64'h0);
        checkOutput("b_issue_x3", 1, 0, 0, 0, 0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1, 1'b1, 3, 3, 0, 15, 1'b0, 3, 1'b0, 0, 64'h0);
        checkOutput("b_x3_busy", 1, 0, 0, 0, 0, 4'b0011, 1'b0, 1'b0);
        applyStimulus(1, 1'b1, 3, 12, 12, 0, 1'b0, 3, 1'b1, 12, 64'h0123456789ABCDEF);
        checkOutput("b_x12_wb_idle", 1, 0, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 0,
                    4'b0001, 1'b0, 1'b0);
        applyStimulus(1, 1'b1, 3, 12, 0, 12, 1'b0, 12, 1'b0, 0, 64'h0);
        checkOutput("b_x12_err", 1, 0, 64'h0123456789ABCDEF, 0, 64'h0123456789ABCDEF,
                    4'b0001, 1'b1, 1'b1);
        applyStimulus(1, 1'b0, 3, 12, 0, 12, 1'b0, 3, 1'b0, 0, 64'h0);
        checkOutput("b_midreset", 1, 0, 0, 0, 0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1, 1'b1, 3, 12, 0, 12, 1'b0, 3, 1'b0, 0, 64'h0);
        checkOutput("b_after_reset", 1, 0, 0, 0, 0, 4'b0000, 1'b1, 1'b0);

        // Give the monitor time to drain; anything left over is a failure.
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
